// File: rtl/imem_loader.sv
// Instruction memory with a streaming program loader.
// A program is streamed in through a valid/ready port. Fetches are serviced
// with a registered 1-cycle read. Addresses at or beyond the loaded length
// return HALT_WORD and raise a one-cycle fault.
module imem_loader #(
  parameter int               DATA_W    = 32,
  parameter int               ADDR_W    = 5,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFC000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] I,
  output logic [DATA_W-1:0] ID,
  output logic              id_valid,
  output logic              fault,
  output logic [ADDR_W:0]   prog_len,
  output logic              loading
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic              xfer;      // loader word accepted this cycle
  logic              overflow;  // memory filled without ld_last
  logic              clr;       // restart a load: rewind pointer and length
  logic              fetch_go;  // fetch accepted this cycle
  logic              hit;       // fetch address lies inside the loaded program

  // Memory is deliberately left without a reset; prog_len gates visibility.
  logic [DATA_W-1:0] mem [DEPTH];

  assign ld_ready = (state == LOAD);
  assign loading  = (state == LOAD);
  assign fetch_go = fetch_en && (state != LOAD);
  assign hit      = ({1'b0, I} < prog_len);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle load control strobes.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    overflow  = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE, RUN: begin
        // A simultaneous fetch still sees the old prog_len: clr only
        // takes effect at the same edge that registers the fetch result.
        if (load_start) begin
          state_nxt = LOAD;
          clr       = 1'b1;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          xfer = 1'b1;
          if (ld_last) begin
            state_nxt = RUN;
          end else if (&wptr) begin
            // Last slot written and the stream still wants more: stop here.
            state_nxt = RUN;
            overflow  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer and loaded length; length tracks accepted words only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      prog_len <= '0;
    end else if (clr) begin
      wptr     <= '0;
      prog_len <= '0;
    end else if (xfer) begin
      wptr     <= wptr + ADDR_W'(1);
      prog_len <= prog_len + (ADDR_W+1)'(1);
    end
  end

  // Program storage write port.
  always_ff @(posedge clk) begin
    if (xfer) mem[wptr] <= ld_data;
  end

  // Registered fetch result; ID holds when no fetch is serviced and fault
  // is rebuilt every cycle so it can only ever pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID       <= '0;
      id_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      id_valid <= fetch_go;
      fault    <= overflow || (fetch_go && !hit);
      if (fetch_go) ID <= hit ? mem[I] : HALT_WORD;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fetch tables feed a scoreboard queue,
// a negedge monitor pops and compares every id_valid result.
module tb_imem_loader;

  localparam int          DW   = 32;
  localparam int          AW   = 5;
  localparam logic [31:0] HALT = 32'hFC000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] I = '0;
  logic [DW-1:0] ID;
  logic          id_valid;
  logic          fault;
  logic [AW:0]   prog_len;
  logic          loading;

  imem_loader #(.DATA_W(DW), .ADDR_W(AW), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_en(fetch_en), .I(I), .ID(ID), .id_valid(id_valid),
    .fault(fault), .prog_len(prog_len), .loading(loading)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   id;
    logic          flt;
  } fvec_t;

  typedef struct packed {
    logic [31:0] id;
    logic        flt;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  logic [31:0] last_id;

  fvec_t v_idle[$], v_basic[$], v_gap[$], v_ovf[$], v_reload[$], v_rst[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fvec_t fv(input logic [AW-1:0] a, input logic [31:0] d, input logic f);
    fvec_t r;
    r.addr = a; r.id = d; r.flt = f;
    return r;
  endfunction

  // Scoreboard monitor: every id_valid must match the oldest pending fetch.
  always @(negedge clk) begin
    if (!rst && id_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_id_valid: got ID %0h with no fetch pending", ID);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_id", ID, e.id);
        check("fetch_fault", {31'b0, fault}, {31'b0, e.flt});
      end
    end
  end

  // Wait (bounded) until the monitor has consumed all pending fetches.
  task automatic drain();
    for (int k = 0; k < 8 && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Issue a table of fetches back-to-back, one per cycle.
  task automatic run_fetches(input fvec_t v[$]);
    @(posedge clk); #1;
    foreach (v[k]) begin
      fetch_en = 1'b1;
      I = v[k].addr;
      sb.push_back({v[k].id, v[k].flt});
      last_id = v[k].id;
      @(posedge clk); #1;
    end
    fetch_en = 1'b0;
    drain();
  endtask

  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    check("loading_on", {31'b0, loading}, 32'd1);
    check("prog_len_clr", {26'b0, prog_len}, 32'd0);
  endtask

  // One loader word; with gap, first spend an idle cycle poking load_start,
  // fetch_en and junk data, all of which LOAD must ignore.
  task automatic send_word(input logic [31:0] d, input logic last, input logic gap);
    if (gap) begin
      ld_valid = 1'b0; ld_data = 32'hDEADBEEF; ld_last = 1'b1;
      load_start = 1'b1; fetch_en = 1'b1; I = '0;
      @(posedge clk); #1;
      load_start = 1'b0; fetch_en = 1'b0;
    end
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    check("ld_ready", {31'b0, ld_ready}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    // Fetch tables: address, expected ID, expected fault.
    v_idle   = '{fv(0, HALT, 1), fv(5, HALT, 1)};
    v_basic  = '{fv(1, 32'h22, 0), fv(3, HALT, 1), fv(0, 32'h11, 0),
                 fv(2, 32'h33, 0)};
    v_gap    = '{fv(0, 32'hA0, 0), fv(1, 32'hA1, 0), fv(2, 32'hA2, 0),
                 fv(3, 32'hA3, 0), fv(4, HALT, 1), fv(5, HALT, 1)};
    v_ovf    = '{fv(31, 32'h1000001F, 0), fv(0, 32'h10000000, 0),
                 fv(16, 32'h10000010, 0)};
    v_reload = '{fv(1, HALT, 1), fv(0, 32'hAB, 0), fv(31, HALT, 1)};
    v_rst    = '{fv(0, HALT, 1), fv(1, HALT, 1)};

    // Reset state.
    #3;
    check("rst_ID", ID, 32'd0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_prog_len", {26'b0, prog_len}, 32'd0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_loading", {31'b0, loading}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Nothing loaded yet: every fetch halts.
    run_fetches(v_idle);

    // Basic 3-word load, then hits, miss at prog_len, back-to-back.
    start_load();
    send_word(32'h11, 1'b0, 1'b0);
    send_word(32'h22, 1'b0, 1'b0);
    send_word(32'h33, 1'b1, 1'b0);
    check("basic_prog_len", {26'b0, prog_len}, 32'd3);
    check("basic_loading_off", {31'b0, loading}, 32'd0);
    run_fetches(v_basic);
    repeat (3) @(posedge clk);
    #1;
    check("hold_ID", ID, last_id);
    check("hold_id_valid", {31'b0, id_valid}, 32'd0);
    check("fault_not_sticky", {31'b0, fault}, 32'd0);

    // Gapped load restarted from RUN; stray requests in LOAD are ignored.
    start_load();
    for (int k = 0; k < 4; k++) send_word(32'hA0 + k, k == 3, 1'b1);
    check("gap_prog_len", {26'b0, prog_len}, 32'd4);
    run_fetches(v_gap);

    // Overflow: 32 words without ld_last.
    start_load();
    for (int k = 0; k < 32; k++) send_word(32'h10000000 + k, 1'b0, 1'b0);
    check("ovf_fault", {31'b0, fault}, 32'd1);
    check("ovf_prog_len", {26'b0, prog_len}, 32'd32);
    check("ovf_loading_off", {31'b0, loading}, 32'd0);
    check("ovf_ld_ready_off", {31'b0, ld_ready}, 32'd0);
    ld_valid = 1'b1; ld_data = 32'h55555555;
    @(posedge clk); #1 ld_valid = 1'b0;
    check("ovf_fault_pulse", {31'b0, fault}, 32'd0);
    check("ovf_no_more_words", {26'b0, prog_len}, 32'd32);
    run_fetches(v_ovf);

    // load_start with a fetch in RUN: fetch uses the old length.
    @(posedge clk); #1;
    load_start = 1'b1; fetch_en = 1'b1; I = '0;
    sb.push_back({32'h10000000, 1'b0});
    @(posedge clk); #1;
    load_start = 1'b0; fetch_en = 1'b0;
    check("restart_loading", {31'b0, loading}, 32'd1);
    check("restart_prog_len", {26'b0, prog_len}, 32'd0);
    drain();
    send_word(32'hAB, 1'b1, 1'b0);
    check("reload_prog_len", {26'b0, prog_len}, 32'd1);
    run_fetches(v_reload);

    // Reset in the middle of a 4-word load.
    start_load();
    send_word(32'hC0, 1'b0, 1'b0);
    send_word(32'hC1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("mid_rst_ID", ID, 32'd0);
    check("mid_rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("mid_rst_fault", {31'b0, fault}, 32'd0);
    check("mid_rst_prog_len", {26'b0, prog_len}, 32'd0);
    check("mid_rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    check("mid_rst_loading", {31'b0, loading}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_fetches(v_rst);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
